alu_exec_ctrl: RTL and testbench

Multi-cycle execution sequencer that drives the 16-bit ALU, the external multiplier and the memory port. It generates the ALU's active-low enable and `exec2` strobe, register and carry write-enables, and PC increment/load, all from the current opcode. It sits between the instruction register and the ALU/register-file/PC datapath. Each instruction runs through FETCH, EXEC1 and, for some opcodes, MULW/EXEC2 or MEM.

---
 rtl/alu_exec_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl -- multi-cycle execution sequencer for the 16-bit ALU datapath.
//
// Runs each instruction through FETCH, EXEC1 and, depending on the opcode,
// MULW/EXEC2 (multiplier) or MEM (load/store).
//
// It generates the following controls as Mealy decodes of state, opcode and
// the inputs:
//   - ALU enable and exec2 strobe
//   - register-file and carry write enables
//   - PC increment/load
//   - memory request/write
//
// Parameters:
//   MUL_TIMEOUT    maximum MULW cycles before a fault is raised (1..255);
//                  used only with the watchdog compiled in.
//
// Configuration macro:
//   ALU_EXEC_MUL_WATCHDOG_EN  builds the MULW watchdog counter and the
//                             sticky fault flag. Without it, MULW waits
//                             indefinitely and fault is tied 0.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   run             start execution from HALT
//   mem_ready       memory completes the current fetch/load/store
//   opcode[5:0]     instruction register opcode field
//   jump            ALU jump condition
//   mul_done        multiplier result valid
//   ir_load         latch fetched instruction
//   mem_req         memory access request
//   mem_we          memory write (store)
//   alu_enable_n    ALU enable, active low
//   exec2           ALU takes multiplier result
//   mul_start       one-cycle multiplier launch
//   reg_we          register-file write of Rd
//   mem_to_reg      write-back source is memory data
//   carry_we        update carry flip-flop
//   pc_inc          PC += 1
//   pc_load         PC = ALU result
//   halted          controller in HALT
//   fault           sticky multiplier-timeout flag
//   state[2:0]      HALT=0, FETCH=1, EXEC1=2, MULW=3, EXEC2=4, MEM=5
module alu_exec_ctrl #(
  parameter int unsigned MUL_TIMEOUT = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  input  logic       jump,
  input  logic       mul_done,
  output logic       ir_load,
  output logic       mem_req,
  output logic       mem_we,
  output logic       alu_enable_n,
  output logic       exec2,
  output logic       mul_start,
  output logic       reg_we,
  output logic       mem_to_reg,
  output logic       carry_we,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_MULW  = 3'd3,
    S_EXEC2 = 3'd4,
    S_MEM   = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   fault_q;
  logic   wd_expire;

  // Opcode classes
  logic op_stp, op_jmp, op_ldr, op_str, op_mul, op_log, op_ari;

  always_comb begin
    op_stp = (opcode == 6'b111111);
    op_jmp = (opcode == 6'b000000) || (opcode inside {[6'b000100:6'b001011]});
    op_ldr = (opcode == 6'b000001);
    op_str = (opcode == 6'b000010);
    op_mul = opcode inside {[6'b011100:6'b011110]};
    op_log = (opcode inside {[6'b001100:6'b010011]}) || (opcode == 6'b011111);
    op_ari = opcode inside {[6'b010100:6'b010110], [6'b011000:6'b011010],
                            [6'b100000:6'b100010], [6'b100100:6'b100101]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_load      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    alu_enable_n = 1'b1;
    exec2        = 1'b0;
    mul_start    = 1'b0;
    reg_we       = 1'b0;
    mem_to_reg   = 1'b0;
    carry_we     = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    halted       = 1'b0;

    unique case (state_q)
      S_HALT: begin
        halted = 1'b1;
        if (run && !fault_q) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_EXEC1;
        end
      end

      S_EXEC1: begin
        alu_enable_n = 1'b0;
        state_d      = S_FETCH;
        if (op_stp) begin
          state_d = S_HALT;
        end else if (op_jmp) begin
          pc_load = jump;
          pc_inc  = !jump;
        end else if (op_ldr || op_str) begin
          alu_enable_n = 1'b1;
          state_d      = S_MEM;
        end else if (op_mul) begin
          mul_start = 1'b1;
          state_d   = S_MULW;
        end else if (op_log) begin
          reg_we = 1'b1;
          pc_inc = 1'b1;
        end else if (op_ari) begin
          reg_we   = 1'b1;
          carry_we = 1'b1;
          pc_inc   = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
      end

      S_MULW: begin
        alu_enable_n = 1'b0;
        // A result arriving on the timeout cycle still completes normally.
        if (mul_done) begin
          state_d = S_EXEC2;
        end else if (wd_expire) begin
          state_d = S_HALT;
        end
      end

      S_EXEC2: begin
        alu_enable_n = 1'b0;
        exec2        = 1'b1;
        reg_we       = 1'b1;
        pc_inc       = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = op_str;
        if (mem_ready) begin
          pc_inc     = 1'b1;
          reg_we     = op_ldr;
          mem_to_reg = op_ldr;
          state_d    = S_FETCH;
        end
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

`ifdef ALU_EXEC_MUL_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       fault_d;

  assign wd_expire = ((wd_cnt_q + 8'd1) == 8'(MUL_TIMEOUT));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == S_EXEC1 && state_d == S_MULW) begin
      wd_cnt_d = '0;
    end else if (state_q == S_MULW && !mul_done) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
    end
    fault_d = fault_q || (state_q == S_MULW && !mul_done && wd_expire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      fault_q  <= fault_d;
    end
  end
`else
  // Timeout value is meaningless without the watchdog; keep it referenced.
  logic unused_timeout;
  assign unused_timeout = ^8'(MUL_TIMEOUT);
  assign wd_expire      = 1'b0;
  assign fault_q        = 1'b0;
`endif

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: instruction-level reference model
// producing the expected per-cycle state/control sequence for each
// randomized instruction, plus reset and watchdog scenarios.
module tb_alu_exec_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst_n, run, mem_ready, jump, mul_done;
  logic [5:0] opcode;
  logic       ir_load, mem_req, mem_we, alu_enable_n, exec2, mul_start;
  logic       reg_we, mem_to_reg, carry_we, pc_inc, pc_load, halted, fault;
  logic [2:0] state;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.MUL_TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_ready(mem_ready),
    .opcode(opcode), .jump(jump), .mul_done(mul_done),
    .ir_load(ir_load), .mem_req(mem_req), .mem_we(mem_we),
    .alu_enable_n(alu_enable_n), .exec2(exec2), .mul_start(mul_start),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .carry_we(carry_we),
    .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted), .fault(fault),
    .state(state)
  );

  // Output vector bit masks
  localparam logic [12:0] O_IRL = 13'h1000, O_MRQ = 13'h0800, O_MWE = 13'h0400,
                          O_AEN = 13'h0200, O_EX2 = 13'h0100, O_MST = 13'h0080,
                          O_RWE = 13'h0040, O_M2R = 13'h0020, O_CWE = 13'h0010,
                          O_PCI = 13'h0008, O_PCL = 13'h0004, O_HLT = 13'h0002,
                          O_FLT = 13'h0001;

  logic [12:0] outs_w;
  assign outs_w = {ir_load, mem_req, mem_we, alu_enable_n, exec2, mul_start,
                   reg_we, mem_to_reg, carry_we, pc_inc, pc_load, halted, fault};

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  typedef enum {C_STP, C_JMP, C_LDR, C_STR, C_MUL, C_LOG, C_ARI, C_NOP} cls_t;

  function automatic cls_t classify(input logic [5:0] op);
    int v;
    v = int'(op);
    if (v == 63) return C_STP;
    if (v == 0 || (v >= 4 && v <= 11)) return C_JMP;
    if (v == 1) return C_LDR;
    if (v == 2) return C_STR;
    if (v >= 28 && v <= 30) return C_MUL;
    if ((v >= 12 && v <= 19) || v == 31) return C_LOG;
    if ((v >= 20 && v <= 22) || (v >= 24 && v <= 26) ||
        (v >= 32 && v <= 34) || v == 36 || v == 37) return C_ARI;
    return C_NOP;
  endfunction

  // One clock cycle: apply inputs, check Mealy outputs mid-cycle, advance.
  task automatic step(input string tag, input logic rn, input logic mr,
                      input logic md, input logic jp, input int exp_st,
                      input logic [12:0] exp_o);
    run = rn; mem_ready = mr; mul_done = md; jump = jp;
    @(negedge clk);
    check({tag, " state"}, 16'(state), 16'(exp_st));
    check({tag, " outs"}, 16'(outs_w), 16'(exp_o));
    @(posedge clk); #1;
  endtask

  // Runs one full instruction starting in FETCH; ends in FETCH (or HALT->FETCH for STP).
  task automatic do_instr(input logic [5:0] op, input logic jp, input int fw,
                          input int mw, input int uw);
    cls_t        c;
    logic        jin;
    logic [12:0] e;
    logic [12:0] wem;
    c = classify(op);
    opcode = op;
    for (int i = 0; i < fw; i++)
      step("fetch wait", rb(), 1'b0, rb(), rb(), 1, O_AEN | O_MRQ);
    step("fetch", rb(), 1'b1, rb(), rb(), 1, O_AEN | O_MRQ | O_IRL);

    jin = (c == C_JMP) ? jp : rb();
    case (c)
      C_STP:   e = '0;
      C_JMP:   e = jin ? O_PCL : O_PCI;
      C_LDR:   e = O_AEN;
      C_STR:   e = O_AEN;
      C_MUL:   e = O_MST;
      C_LOG:   e = O_RWE | O_PCI;
      C_ARI:   e = O_RWE | O_CWE | O_PCI;
      default: e = O_PCI;
    endcase
    step($sformatf("exec1 op=%b", op), rb(), rb(), rb(), jin, 2, e);

    case (c)
      C_LDR, C_STR: begin
        wem = (c == C_STR) ? O_MWE : 13'h0;
        for (int i = 0; i < mw; i++)
          step($sformatf("mem wait op=%b", op), rb(), 1'b0, rb(), rb(), 5, O_AEN | O_MRQ | wem);
        step($sformatf("mem done op=%b", op), rb(), 1'b1, rb(), rb(), 5,
             O_AEN | O_MRQ | wem | O_PCI | ((c == C_LDR) ? (O_RWE | O_M2R) : 13'h0));
      end
      C_MUL: begin
        for (int i = 0; i < uw; i++)
          step("mulw wait", rb(), rb(), 1'b0, rb(), 3, 13'h0);
        step("mulw done", rb(), rb(), 1'b1, rb(), 3, 13'h0);
        step("exec2", rb(), rb(), rb(), rb(), 4, O_EX2 | O_RWE | O_PCI);
      end
      C_STP: begin
        for (int i = 0; i < 3; i++)
          step("halt idle", 1'b0, 1'b1, rb(), rb(), 0, O_AEN | O_HLT);
        step("halt run", 1'b1, rb(), rb(), rb(), 0, O_AEN | O_HLT);
      end
      default: ;
    endcase
  endtask

  // Reset while in FETCH (1), MULW (3) or MEM (5); ends in FETCH after restart.
  task automatic reset_in(input int where);
    opcode = (where == 3) ? 6'b011100 : 6'b000001;
    if (where != 1) begin
      step("rst pre fetch", 1'b0, 1'b1, 1'b0, 1'b0, 1, O_AEN | O_MRQ | O_IRL);
      step("rst pre exec1", 1'b0, 1'b0, 1'b0, 1'b0, 2,
           (where == 3) ? O_MST : O_AEN);
    end
    step($sformatf("rst pre wait st%0d", where), 1'b0, 1'b0, 1'b0, 1'b0, where,
         (where == 3) ? 13'h0 : (O_AEN | O_MRQ));
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; mul_done = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step($sformatf("after rst st%0d", where), 1'b0, 1'b1, 1'b1, 1'b1, 0, O_AEN | O_HLT);
    step("restart", 1'b1, 1'b0, 1'b0, 1'b0, 0, O_AEN | O_HLT);
  endtask

  logic [5:0] rop;
  int         uw_max;

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; jump = 1'b0; mul_done = 1'b0;
    opcode = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step("reset halt", 1'b0, 1'b1, 1'b1, 1'b1, 0, O_AEN | O_HLT);
    step("start", 1'b1, 1'b0, 1'b0, 1'b0, 0, O_AEN | O_HLT);

    // Directed instructions
    do_instr(6'b010100, 1'b0, 0, 0, 0);   // ADD
    do_instr(6'b000110, 1'b1, 0, 0, 0);   // JC3 taken
    do_instr(6'b000110, 1'b0, 1, 0, 0);   // JC3 not taken
    do_instr(6'b011101, 1'b0, 0, 0, 2);   // MLA, done on 3rd MULW cycle
    do_instr(6'b000001, 1'b0, 0, 2, 0);   // LDR
    do_instr(6'b000010, 1'b0, 0, 2, 0);   // STR
    do_instr(6'b111111, 1'b0, 0, 0, 0);   // STP
    do_instr(6'b111110, 1'b0, 0, 0, 0);   // NOP
    do_instr(6'b011011, 1'b0, 0, 0, 0);   // unassigned
    do_instr(6'b011111, 1'b0, 0, 0, 0);   // MRT

    // Randomized instruction stream
    uw_max = (TB_TIMEOUT > 1) ? int'(TB_TIMEOUT) - 1 : 0;
    if (uw_max > 6) uw_max = 6;
    for (int n = 0; n < 200; n++) begin
      rop = 6'($urandom);
      do_instr(rop, rb(), int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
               int'($urandom_range(uw_max, 0)));
    end

    reset_in(1);
    reset_in(3);
    reset_in(5);

`ifdef ALU_EXEC_MUL_WATCHDOG_EN
    // Done on the final allowed cycle still completes.
    do_instr(6'b011100, 1'b0, 0, 0, int'(TB_TIMEOUT) - 1);
    // Timeout: fault sticks, run ignored, reset clears.
    opcode = 6'b011110;
    step("wd fetch", 1'b0, 1'b1, 1'b0, 1'b0, 1, O_AEN | O_MRQ | O_IRL);
    step("wd exec1", 1'b0, 1'b0, 1'b0, 1'b0, 2, O_MST);
    for (int i = 0; i < int'(TB_TIMEOUT); i++)
      step("wd mulw", rb(), rb(), 1'b0, rb(), 3, 13'h0);
    for (int i = 0; i < 3; i++)
      step("wd halted", 1'b1, rb(), rb(), rb(), 0, O_AEN | O_HLT | O_FLT);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("wd after rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, O_AEN | O_HLT);
    step("wd restart", 1'b1, 1'b0, 1'b0, 1'b0, 0, O_AEN | O_HLT);
    reset_in(3);
`else
    // Without the watchdog a long multiply simply waits.
    do_instr(6'b011100, 1'b0, 0, 0, 40);
`endif
    do_instr(6'b100101, 1'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
